// File: rtl/mips_mc_control_unit.sv
// mips_mc_control_unit
//   Multi-cycle Moore control unit for a MIPS-I integer subset. One state
//   per clock; every datapath select/enable is a registered function of the
//   state being entered. The exception is the branch pc_ld, which must see
//   the Z flag of the current compare cycle.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   ir         instruction register contents (stable after FETCH)
//   N, C, V    ALU flags, not used by this subset
//   Z          ALU zero flag, looked at only in BR_CMP
//   im_cs/im_rd, ir_ld, pc_inc      instruction fetch controls
//   pc_ld, pc_sel                   PC load and source (0 br, 1 jump, 2 RS)
//   dm_cs/dm_rd/dm_wr               data memory controls
//   D_En, D_sel, Y_Sel, T_Sel       register file write, address, source, RT mux
//   HILO_ld, FS                     HI/LO load and ALU function
//   halt                            unit stopped (BREAK / illegal)
//   state_dbg                       current state encoding

module mips_mc_control_unit #(
  parameter int RESET_STALL = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir,
  input  logic        N,
  input  logic        Z,
  input  logic        C,
  input  logic        V,
  output logic        im_cs,
  output logic        im_rd,
  output logic        ir_ld,
  output logic        pc_inc,
  output logic        pc_ld,
  output logic [1:0]  pc_sel,
  output logic        dm_cs,
  output logic        dm_rd,
  output logic        dm_wr,
  output logic        D_En,
  output logic        T_Sel,
  output logic        HILO_ld,
  output logic [1:0]  D_sel,
  output logic [2:0]  Y_Sel,
  output logic [4:0]  FS,
  output logic        halt,
  output logic [4:0]  state_dbg
);

  typedef enum logic [4:0] {
    RESET   = 5'd0,
    FETCH   = 5'd1,
    DECODE  = 5'd2,
    R_EXE   = 5'd3,
    R_WB    = 5'd4,
    I_EXE   = 5'd5,
    I_WB    = 5'd6,
    LS_ADDR = 5'd7,
    LW_RD   = 5'd8,
    LW_WB   = 5'd9,
    SW_WR   = 5'd10,
    BR_CMP  = 5'd11,
    J_ST    = 5'd12,
    JAL_ST  = 5'd13,
    JAL_J   = 5'd14,
    JR_ST   = 5'd15,
    MD_EXE  = 5'd16,
    MF_WB   = 5'd17,
    HALT    = 5'd18
  } state_t;

  localparam logic [3:0] STALL_LAST = 4'(RESET_STALL - 1);

  localparam logic [5:0] OP_SW = 6'h2B;

  state_t     state, next_state;
  logic [3:0] cnt, next_cnt;

  logic       n_im_cs, n_im_rd, n_ir_ld, n_pc_inc, n_pc_ld;
  logic [1:0] n_pc_sel;
  logic       n_dm_cs, n_dm_rd, n_dm_wr, n_d_en, n_t_sel, n_hilo_ld;
  logic [1:0] n_d_sel;
  logic [2:0] n_y_sel;
  logic [4:0] n_fs;
  logic       n_halt;
  logic       pc_ld_q;

  logic [5:0] opcode, funct;
  assign opcode = ir[31:26];
  assign funct  = ir[5:0];

  // Flags and instruction fields this subset never looks at.
  logic unused_sig;
  assign unused_sig = ^{N, C, V, ir[25:6]};

  // ALU function for the R-type arithmetic/logic group.
  function automatic logic [4:0] r_fs(input logic [5:0] f);
    case (f)
      6'h20:   r_fs = 5'h02;
      6'h21:   r_fs = 5'h03;
      6'h22:   r_fs = 5'h04;
      6'h23:   r_fs = 5'h05;
      6'h2A:   r_fs = 5'h06;
      6'h2B:   r_fs = 5'h07;
      6'h24:   r_fs = 5'h08;
      6'h25:   r_fs = 5'h09;
      6'h26:   r_fs = 5'h0A;
      6'h27:   r_fs = 5'h0B;
      6'h00:   r_fs = 5'h0C;
      6'h02:   r_fs = 5'h0D;
      6'h03:   r_fs = 5'h0E;
      default: r_fs = 5'h00;
    endcase
  endfunction

  // ALU function for the immediate group; ADDI/SLTI reuse ADD/SLT.
  function automatic logic [4:0] i_fs(input logic [5:0] op);
    case (op)
      6'h08:   i_fs = 5'h02;
      6'h0A:   i_fs = 5'h06;
      6'h0C:   i_fs = 5'h16;
      6'h0D:   i_fs = 5'h17;
      6'h0E:   i_fs = 5'h19;
      6'h0F:   i_fs = 5'h18;
      default: i_fs = 5'h00;
    endcase
  endfunction

  // First execution state for the instruction in ir; anything not
  // recognised (including BREAK) stops the unit.
  function automatic state_t decode_target(input logic [5:0] op, input logic [5:0] f);
    decode_target = HALT;
    case (op)
      6'h00: begin
        case (f)
          6'h20, 6'h21, 6'h22, 6'h23, 6'h2A, 6'h2B,
          6'h24, 6'h25, 6'h26, 6'h27,
          6'h00, 6'h02, 6'h03:           decode_target = R_EXE;
          6'h08:                         decode_target = JR_ST;
          6'h18, 6'h1A:                  decode_target = MD_EXE;
          6'h10, 6'h12:                  decode_target = MF_WB;
          default:                       decode_target = HALT;
        endcase
      end
      6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F: decode_target = I_EXE;
      6'h23, 6'h2B:                      decode_target = LS_ADDR;
      6'h04, 6'h05:                      decode_target = BR_CMP;
      6'h02:                             decode_target = J_ST;
      6'h03:                             decode_target = JAL_ST;
      default:                           decode_target = HALT;
    endcase
  endfunction

  // Next state, then the output word of that next state so it can be
  // registered alongside it.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      RESET: begin
        if (cnt == STALL_LAST) begin
          next_state = FETCH;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + 4'd1;
        end
      end
      FETCH:   next_state = DECODE;
      DECODE:  next_state = decode_target(opcode, funct);
      R_EXE:   next_state = R_WB;
      I_EXE:   next_state = I_WB;
      LS_ADDR: next_state = (opcode == OP_SW) ? SW_WR : LW_RD;
      LW_RD:   next_state = LW_WB;
      JAL_ST:  next_state = JAL_J;
      HALT:    next_state = HALT;
      default: next_state = FETCH;
    endcase

    n_im_cs   = 1'b0;
    n_im_rd   = 1'b0;
    n_ir_ld   = 1'b0;
    n_pc_inc  = 1'b0;
    n_pc_ld   = 1'b0;
    n_pc_sel  = 2'd0;
    n_dm_cs   = 1'b0;
    n_dm_rd   = 1'b0;
    n_dm_wr   = 1'b0;
    n_d_en    = 1'b0;
    n_t_sel   = 1'b0;
    n_hilo_ld = 1'b0;
    n_d_sel   = 2'd0;
    n_y_sel   = 3'd0;
    n_fs      = 5'h00;
    n_halt    = 1'b0;
    case (next_state)
      FETCH: begin
        n_im_cs  = 1'b1;
        n_im_rd  = 1'b1;
        n_ir_ld  = 1'b1;
        n_pc_inc = 1'b1;
      end
      R_EXE:   n_fs = r_fs(funct);
      R_WB: begin
        n_y_sel = 3'd2;
        n_d_sel = 2'd0;
        n_d_en  = 1'b1;
      end
      I_EXE: begin
        n_t_sel = 1'b1;
        n_fs    = i_fs(opcode);
      end
      I_WB: begin
        n_y_sel = 3'd2;
        n_d_sel = 2'd1;
        n_d_en  = 1'b1;
      end
      LS_ADDR: begin
        n_t_sel = 1'b1;
        n_fs    = 5'h02;
      end
      LW_RD: begin
        n_dm_cs = 1'b1;
        n_dm_rd = 1'b1;
      end
      LW_WB: begin
        n_y_sel = 3'd3;
        n_d_sel = 2'd1;
        n_d_en  = 1'b1;
      end
      SW_WR: begin
        n_dm_cs = 1'b1;
        n_dm_wr = 1'b1;
      end
      BR_CMP:  n_fs = 5'h04;
      J_ST: begin
        n_pc_sel = 2'd1;
        n_pc_ld  = 1'b1;
      end
      JAL_ST: begin
        n_y_sel = 3'd4;
        n_d_sel = 2'd2;
        n_d_en  = 1'b1;
      end
      JAL_J: begin
        n_pc_sel = 2'd1;
        n_pc_ld  = 1'b1;
      end
      JR_ST: begin
        n_pc_sel = 2'd2;
        n_pc_ld  = 1'b1;
      end
      MD_EXE: begin
        n_fs      = funct[1] ? 5'h1F : 5'h1E;
        n_hilo_ld = 1'b1;
      end
      MF_WB: begin
        n_y_sel = funct[1] ? 3'd1 : 3'd0;
        n_d_sel = 2'd0;
        n_d_en  = 1'b1;
      end
      HALT:    n_halt = 1'b1;
      default: ;
    endcase
  end

  // State, stall counter and the registered output word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= RESET;
      cnt     <= '0;
      im_cs   <= 1'b0;
      im_rd   <= 1'b0;
      ir_ld   <= 1'b0;
      pc_inc  <= 1'b0;
      pc_ld_q <= 1'b0;
      pc_sel  <= 2'd0;
      dm_cs   <= 1'b0;
      dm_rd   <= 1'b0;
      dm_wr   <= 1'b0;
      D_En    <= 1'b0;
      T_Sel   <= 1'b0;
      HILO_ld <= 1'b0;
      D_sel   <= 2'd0;
      Y_Sel   <= 3'd0;
      FS      <= 5'h00;
      halt    <= 1'b0;
    end else begin
      state   <= next_state;
      cnt     <= next_cnt;
      im_cs   <= n_im_cs;
      im_rd   <= n_im_rd;
      ir_ld   <= n_ir_ld;
      pc_inc  <= n_pc_inc;
      pc_ld_q <= n_pc_ld;
      pc_sel  <= n_pc_sel;
      dm_cs   <= n_dm_cs;
      dm_rd   <= n_dm_rd;
      dm_wr   <= n_dm_wr;
      D_En    <= n_d_en;
      T_Sel   <= n_t_sel;
      HILO_ld <= n_hilo_ld;
      D_sel   <= n_d_sel;
      Y_Sel   <= n_y_sel;
      FS      <= n_fs;
      halt    <= n_halt;
    end
  end

  // The branch decision needs Z from the compare cycle itself, so it cannot
  // be registered ahead of time. ir[26] separates BNE (1) from BEQ (0).
  logic br_take;
  assign br_take   = (state == BR_CMP) && (Z ^ ir[26]);
  assign pc_ld     = pc_ld_q | br_take;
  assign state_dbg = state;

endmodule
